// File: rtl/geofence_pkg.sv
// Shared types for the geofence transmit path.
// Record layout, widths and driver FSM states.
package geofence_pkg;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int RW = 11;
  localparam int NPTS_DEF = 6;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [RW-1:0] r;
  } rec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_REPORT
  } state_t;

endpackage

// File: rtl/geofence_pp_buf.sv
// Ping-pong record buffer: loader fills one bank
// while the driver reads the other.
module geofence_pp_buf
  import geofence_pkg::*;
#(
  parameter int NPTS = NPTS_DEF,
  localparam int PW = $clog2(NPTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  rec_t          wr_data,
  input  logic [PW-1:0] rd_idx,
  input  logic          free,
  output logic          fill_full,
  output logic          send_full,
  output rec_t          rd_data
);

  rec_t          mem [2][NPTS];
  logic [1:0]    full;
  logic          fill_sel;
  logic          send_sel;
  logic [PW-1:0] wp;
  logic          wr_ok;
  logic          wr_last;

  assign wr_ok = wr_en && !full[fill_sel];
  assign wr_last = wr_ok && (wp == PW'(NPTS - 1));

  // Banks are only ever written while not full and freed while
  // full, so fill and free always touch different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NPTS; i++)
          mem[b][i] <= '0;
      full <= '0;
      fill_sel <= 1'b0;
      send_sel <= 1'b0;
      wp <= '0;
    end else begin
      if (wr_ok) begin
        mem[fill_sel][wp] <= wr_data;
        wp <= wr_last ? '0 : wp + 1'b1;
      end
      if (wr_last) begin
        full[fill_sel] <= 1'b1;
        fill_sel <= ~fill_sel;
      end
      if (free) begin
        full[send_sel] <= 1'b0;
        send_sel <= ~send_sel;
      end
    end
  end

  assign fill_full = full[fill_sel];
  assign send_full = full[send_sel];
  assign rd_data = mem[send_sel][rd_idx];

endmodule

// File: rtl/geofence_driver.sv
// Streams buffered receiver records to geofence and
// returns a tagged inside/timeout result per test.
module geofence_driver
  import geofence_pkg::*;
#(
  parameter int NPTS = NPTS_DEF,
  parameter int TIMEOUT = 1023,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XW-1:0]   ld_x,
  input  logic [YW-1:0]   ld_y,
  input  logic [RW-1:0]   ld_r,
  output logic [XW-1:0]   X,
  output logic [YW-1:0]   Y,
  output logic [RW-1:0]   R,
  output logic            gf_send,
  input  logic            valid,
  input  logic            is_inside,
  output logic            res_valid,
  output logic            res_inside,
  output logic            res_timeout,
  output logic [TAGW-1:0] res_tag
);

  localparam int PW = $clog2(NPTS);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   rp;
  logic [CW-1:0]   cnt;
  logic [TAGW-1:0] tag;
  logic            inside_q;
  logic            tmo_q;
  logic            err;
  logic            rdy_en;
  logic            fill_full;
  logic            send_full;
  logic            last_rec;
  logic            cnt_hit;
  rec_t            wr_data;
  rec_t            rd_data;

  assign ld_ready = rdy_en && !fill_full;
  assign wr_data = '{x: ld_x, y: ld_y, r: ld_r};
  assign last_rec = (rp == PW'(NPTS - 1));
  assign cnt_hit = ((cnt + 1'b1) == CW'(TIMEOUT));

  geofence_pp_buf #(.NPTS(NPTS)) u_buf (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en     (ld_valid && ld_ready),
    .wr_data   (wr_data),
    .rd_idx    (rp),
    .free      (state == S_REPORT),
    .fill_full (fill_full),
    .send_full (send_full),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (send_full) state_nx = S_SEND;
      S_SEND:   if (last_rec) state_nx = S_WAIT;
      S_WAIT:   if (valid || cnt_hit) state_nx = S_REPORT;
      S_REPORT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // rdy_en holds ld_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp <= '0;
      cnt <= '0;
      tag <= '0;
      inside_q <= 1'b0;
      tmo_q <= 1'b0;
      err <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (valid && state != S_WAIT) err <= 1'b1;
      case (state)
        S_IDLE: rp <= '0;
        S_SEND: begin
          rp <= last_rec ? '0 : rp + 1'b1;
          cnt <= '0;
        end
        S_WAIT: begin
          if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
          if (valid) begin
            inside_q <= is_inside;
            tmo_q <= 1'b0;
          end else if (cnt_hit) begin
            inside_q <= 1'b0;
            tmo_q <= 1'b1;
          end
        end
        S_REPORT: tag <= tag + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    X = '0;
    Y = '0;
    R = '0;
    gf_send = 1'b0;
    res_valid = 1'b0;
    res_inside = 1'b0;
    res_timeout = 1'b0;
    res_tag = '0;
    if (state == S_SEND) begin
      X = rd_data.x;
      Y = rd_data.y;
      R = rd_data.r;
      gf_send = 1'b1;
    end
    if (state == S_REPORT) begin
      res_valid = 1'b1;
      res_inside = inside_q;
      res_timeout = tmo_q;
      res_tag = tag;
    end
  end

endmodule

// File: tb/tb_geofence_driver.sv
// Directed + random bench for geofence_driver with a
// transaction-level model of loading, streaming and results.
module tb_geofence_driver;

  localparam int NPTS = 6;
  localparam int TMO = 15;
  localparam int TAGW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [9:0]      ld_x = '0;
  logic [9:0]      ld_y = '0;
  logic [10:0]     ld_r = '0;
  logic [9:0]      X;
  logic [9:0]      Y;
  logic [10:0]     R;
  logic            gf_send;
  logic            valid = 1'b0;
  logic            is_inside = 1'b0;
  logic            res_valid;
  logic            res_inside;
  logic            res_timeout;
  logic [TAGW-1:0] res_tag;

  geofence_driver #(.NPTS(NPTS), .TIMEOUT(TMO), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_x(ld_x), .ld_y(ld_y), .ld_r(ld_r), .X(X), .Y(Y), .R(R),
    .gf_send(gf_send), .valid(valid), .is_inside(is_inside),
    .res_valid(res_valid), .res_inside(res_inside),
    .res_timeout(res_timeout), .res_tag(res_tag)
  );

  always #5 clk = ~clk;

  int nasrt = 0;
  int nfail = 0;
  int cyc = 0;
  logic [30:0] ld_q[$];
  logic [30:0] exp_q[$];
  int lat_q[$];
  bit ins_q[$];
  int done_cyc[$];
  int seen, res_cyc, vcyc, done, reported, nacc, prev_rep, tag_m;
  int gap_pct = 0;
  bit vin, exp_in, exp_to, stray;

  task automatic ck(string tag, logic [31:0] obs, logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    ld_q.delete(); exp_q.delete(); lat_q.delete();
    ins_q.delete(); done_cyc.delete();
    seen = 0; res_cyc = -1; vcyc = -1; done = 0; reported = 0;
    nacc = 0; tag_m = 0; prev_rep = -100; stray = 0;
  endtask

  // lat = cycles from last record to valid; 0 = geofence never answers
  task automatic add_test(bit dir, int lat, bit ins);
    logic [30:0] r;
    for (int i = 1; i <= NPTS; i++) begin
      if (dir) r = {10'(10 * i), 10'(10 * i + 10), 11'(10 * i + 20)};
      else r = 31'($urandom);
      ld_q.push_back(r);
    end
    lat_q.push_back(lat);
    ins_q.push_back(ins);
  endtask

  task automatic zero_chk(string tag);
    ck({tag, "_gf_send"}, gf_send, 0);
    ck({tag, "_xyr"}, {X, Y, R}, 0);
    ck({tag, "_ld_ready"}, ld_ready, 0);
    ck({tag, "_res"}, {res_valid, res_inside, res_timeout, res_tag}, 0);
  endtask

  task automatic check_cycle();
    int st;
    int lat;
    ck("ld_ready", ld_ready, 32'((done - reported) < 2));
    if (gf_send) begin
      if (exp_q.size() == 0 || done_cyc.size() == 0 && seen == 0) begin
        ck("unexpected_send", gf_send, 0);
      end else begin
        if (seen == 0) begin
          st = done_cyc.pop_front() + 1;
          if (prev_rep + 2 > st) st = prev_rep + 2;
          ck("send_start_cyc", cyc, st);
        end
        ck("record", {X, Y, R}, exp_q.pop_front());
        seen++;
        if (seen == NPTS) begin
          seen = 0;
          lat = lat_q.pop_front();
          vin = ins_q.pop_front();
          if (lat > 0) begin
            vcyc = cyc + lat;
            res_cyc = vcyc + 1;
            exp_in = vin;
            exp_to = 1'b0;
          end else begin
            res_cyc = cyc + TMO + 1;
            exp_in = 1'b0;
            exp_to = 1'b1;
          end
        end
      end
    end else begin
      ck("no_bubble", seen, 0);
      ck("xyr_idle", {X, Y, R}, 0);
    end
    ck("res_valid", res_valid, 32'(cyc == res_cyc));
    if (res_valid && cyc == res_cyc) begin
      ck("res_inside", res_inside, exp_in);
      ck("res_timeout", res_timeout, exp_to);
      ck("res_tag", res_tag, tag_m);
      tag_m = (tag_m + 1) % (1 << TAGW);
      prev_rep = cyc;
      res_cyc = -1;
    end
  endtask

  task automatic tick();
    bit drv, acc, was_rep;
    drv = (ld_q.size() != 0) && ($urandom_range(99) >= gap_pct);
    ld_valid = drv;
    if (drv) {ld_x, ld_y, ld_r} = ld_q[0];
    else {ld_x, ld_y, ld_r} = 31'($urandom);
    valid = (cyc == vcyc) || stray;
    is_inside = (cyc == vcyc) ? vin : 1'($urandom);
    acc = drv && ld_ready;
    was_rep = res_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      exp_q.push_back(ld_q.pop_front());
      nacc++;
      if (nacc % NPTS == 0) begin
        done++;
        done_cyc.push_back(cyc);
      end
    end
    if (was_rep) reported++;
    check_cycle();
  endtask

  task automatic run(int budget, int stop_at);
    int n = 0;
    while ((ld_q.size() != 0 || exp_q.size() != 0 || res_cyc >= 0
            || seen != 0) && n < budget) begin
      tick();
      n++;
      if (stop_at > 0 && seen == stop_at) return;
    end
    ck("run_in_budget", 32'(n < budget), 1);
  endtask

  initial begin
    mreset();
    repeat (3) @(posedge clk);
    #1;
    cyc = 3;
    zero_chk("in_reset");
    #2 reset = 1'b1;
    ck("ready_before_edge", ld_ready, 0);
    tick();

    // directed single test
    add_test(1, 3, 1);
    run(300, 0);

    // back-to-back, continuous loading
    gap_pct = 0;
    for (int t = 0; t < 3; t++) add_test(0, $urandom_range(1, 14), 1'($urandom));
    run(600, 0);

    // timeout then a normal test
    add_test(0, 0, 1);
    add_test(0, $urandom_range(1, 14), 1);
    run(600, 0);
    ck("err_clear", dut.err, 0);

    // stray valid in IDLE
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    ck("err_set", dut.err, 1);
    add_test(0, 2, 0);
    run(300, 0);

    // random loader gaps and latencies
    gap_pct = 30;
    for (int t = 0; t < 4; t++) add_test(0, $urandom_range(0, 14), 1'($urandom));
    run(1500, 0);
    ck("err_sticky", dut.err, 1);

    // reset in the middle of SEND
    gap_pct = 0;
    add_test(0, 4, 1);
    run(300, 3);
    #2 reset = 1'b0;
    #1;
    zero_chk("mid_reset");
    ck("err_reset", dut.err, 0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #2 reset = 1'b1;
    ck("ready_after_rel", ld_ready, 0);
    mreset();
    tick();
    repeat (3) tick();
    add_test(0, 5, 1);
    run(300, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
